// File: rtl/ps2_keycode.sv
// PS/2 keyboard receiver: synchronizes the device bus, frames Set-2 bytes with
// odd parity and an inactivity timeout, and tracks up to two held keys as USB usages.
module ps2_keycode #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] keycode,
    output logic [7:0]  scan_byte,
    output logic        byte_valid,
    output logic        frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    // Receive handshake: byte_valid is a one-cycle strobe qualifying scan_byte;
    // there is no ready, the decoder consumes every strobe in the cycle it appears.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_t;

    rx_state_t     state, state_next;
    logic [2:0]    clk_sync;
    logic [1:0]    data_sync;
    logic [2:0]    bit_cnt, bit_cnt_next;
    logic [7:0]    shift, shift_next;
    logic          parity, parity_next;
    logic [TW-1:0] tcnt, tcnt_next;
    logic [7:0]    scan_next;
    logic          bv_next, fe_next;
    logic          fall, sample;
    logic          brk_flag, ext_flag;
    logic [7:0]    usage;

    // clk_sync[2] holds the previous synchronized ps2_clk for edge detection.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            clk_sync  <= 3'b111;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[1:0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    assign fall   = clk_sync[2] & ~clk_sync[1];
    assign sample = data_sync[1];

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            parity     <= 1'b0;
            tcnt       <= '0;
            scan_byte  <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_next;
            bit_cnt    <= bit_cnt_next;
            shift      <= shift_next;
            parity     <= parity_next;
            tcnt       <= tcnt_next;
            scan_byte  <= scan_next;
            byte_valid <= bv_next;
            frame_err  <= fe_next;
        end
    end

    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        shift_next   = shift;
        parity_next  = parity;
        tcnt_next    = tcnt;
        scan_next    = scan_byte;
        bv_next      = 1'b0;
        fe_next      = 1'b0;
        if (state == ST_IDLE) begin
            tcnt_next = '0;
            if (fall && !sample) begin
                state_next   = ST_DATA;
                bit_cnt_next = '0;
            end
        end else if (fall) begin
            tcnt_next = '0;
            case (state)
                ST_DATA: begin
                    shift_next   = {sample, shift[7:1]};
                    bit_cnt_next = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_next = ST_PARITY;
                end
                ST_PARITY: begin
                    parity_next = sample;
                    state_next  = ST_STOP;
                end
                default: begin
                    // Odd parity across data and parity bits, stop bit must be high.
                    if (sample && (^{parity, shift})) begin
                        bv_next   = 1'b1;
                        scan_next = shift;
                    end else begin
                        fe_next = 1'b1;
                    end
                    state_next = ST_IDLE;
                end
            endcase
        end else if (tcnt == TW'(TIMEOUT_CYCLES)) begin
            state_next = ST_IDLE;
            tcnt_next  = '0;
            fe_next    = 1'b1;
        end else begin
            tcnt_next = tcnt + TW'(1);
        end
    end

    always_comb begin
        case (scan_byte)
            8'h1D:   usage = 8'h1A;
            8'h1B:   usage = 8'h16;
            8'h1C:   usage = 8'h04;
            8'h23:   usage = 8'h07;
            8'h29:   usage = 8'h2C;
            8'h5A:   usage = 8'h28;
            default: usage = 8'h00;
        endcase
    end

    // Slot0 always holds the oldest key; slot1 drops into slot0 when slot0 is released.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            brk_flag <= 1'b0;
            ext_flag <= 1'b0;
            keycode  <= '0;
        end else if (byte_valid) begin
            if (scan_byte == 8'hF0) begin
                brk_flag <= 1'b1;
            end else if (scan_byte == 8'hE0) begin
                ext_flag <= 1'b1;
            end else begin
                brk_flag <= 1'b0;
                ext_flag <= 1'b0;
                if (!ext_flag && usage != 8'h00) begin
                    if (brk_flag) begin
                        if (keycode[7:0] == usage) begin
                            keycode <= {8'h00, keycode[15:8]};
                        end else if (keycode[15:8] == usage) begin
                            keycode[15:8] <= 8'h00;
                        end
                    end else if (keycode[7:0] != usage && keycode[15:8] != usage) begin
                        if (keycode[7:0] == 8'h00) begin
                            keycode[7:0] <= usage;
                        end else if (keycode[15:8] == 8'h00) begin
                            keycode[15:8] <= usage;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_keycode.sv
// Bench for ps2_keycode: drives PS/2 frames, checks each received byte and the
// keycode one clock after it against a queue of expected {keycode, byte} pairs.
module tb_ps2_keycode;

    localparam int HALF = 200;

    logic        clk;
    logic        rst_n;
    logic        ps2_clk;
    logic        ps2_data;
    logic [15:0] keycode;
    logic [7:0]  scan_byte;
    logic        byte_valid;
    logic        frame_err;

    int          n_checks = 0;
    int          n_fail = 0;
    int          err_cnt = 0;
    logic [23:0] exp_q[$];
    logic        pend = 1'b0;
    logic [15:0] pend_kc = '0;

    ps2_keycode dut (
        .Clk        (clk),
        .Reset      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .keycode    (keycode),
        .scan_byte  (scan_byte),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic ps2_bit(input logic b);
        ps2_data = b;
        #(HALF);
        ps2_clk = 1'b0;
        #(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_ok, input logic stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par_ok ? ~(^b) : (^b));
        ps2_bit(stop);
        ps2_data = 1'b1;
        #(2 * HALF);
    endtask

    task automatic send_key(input logic [7:0] b, input logic [15:0] kc);
        exp_q.push_back({kc, b});
        send_frame(b, 1'b1, 1'b1);
    endtask

    task automatic send_bad(input string tag, input logic [7:0] b, input logic par_ok,
                            input logic stop, input logic [15:0] kc);
        int e0;
        e0 = err_cnt;
        send_frame(b, par_ok, stop);
        @(negedge clk);
        check(tag, err_cnt - e0, 1);
        check({tag, "_kc"}, keycode, kc);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [23:0] e;
        if (pend) begin
            check("keycode", keycode, pend_kc);
            pend = 1'b0;
        end
        if (byte_valid || frame_err) check("bv_fe_excl", byte_valid & frame_err, 0);
        if (frame_err) err_cnt++;
        if (byte_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_byte", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("scan_byte", scan_byte, e[7:0]);
                pend    = 1'b1;
                pend_kc = e[23:8];
            end
        end
    end

    initial begin
        int e0;
        rst_n    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_keycode", keycode, 0);
        check("rst_scan", scan_byte, 0);
        check("rst_bv", byte_valid, 0);
        check("rst_fe", frame_err, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // single make/break of W
        send_key(8'h1D, 16'h001A);
        send_key(8'hF0, 16'h001A);
        send_key(8'h1D, 16'h0000);

        // two keys, release first, second drops into slot0
        send_key(8'h1C, 16'h0004);
        send_key(8'h23, 16'h0704);
        send_key(8'hF0, 16'h0704);
        send_key(8'h1C, 16'h0007);
        send_key(8'hF0, 16'h0007);
        send_key(8'h23, 16'h0000);

        send_bad("parity_err", 8'h1B, 1'b0, 1'b1, 16'h0000);

        // both slots full, drop, extended ignored, break of unheld key
        send_key(8'h1D, 16'h001A);
        send_key(8'h1B, 16'h161A);
        send_key(8'h23, 16'h161A);
        send_key(8'hE0, 16'h161A);
        send_key(8'h1D, 16'h161A);
        send_key(8'hF0, 16'h161A);
        send_key(8'h23, 16'h161A);
        send_key(8'hF0, 16'h161A);
        send_key(8'h1D, 16'h0016);
        send_key(8'hF0, 16'h0016);
        send_key(8'h1B, 16'h0000);
        send_key(8'h15, 16'h0000);

        send_bad("stop_err", 8'h29, 1'b1, 1'b0, 16'h0000);

        // partial frame then idle bus
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        e0 = err_cnt;
        repeat (50010) @(negedge clk);
        check("timeout_err", err_cnt - e0, 1);
        send_key(8'h29, 16'h002C);

        // reset during a frame
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(i[0]);
        e0 = err_cnt;
        @(negedge clk);
        rst_n    = 1'b0;
        ps2_data = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_keycode", keycode, 0);
        check("midrst_scan", scan_byte, 0);
        check("midrst_bv", byte_valid, 0);
        check("midrst_fe", frame_err, 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("midrst_no_err", err_cnt - e0, 0);
        send_key(8'h5A, 16'h0028);

        // random unmapped bytes leave keycode alone
        for (int i = 0; i < 4; i++) begin
            send_key(8'($urandom_range(8'h30, 8'h50)), 16'h0028);
        end

        repeat (10) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        check("err_total", err_cnt, 3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
